alu_card_sequencer: RTL

//  Master-side driver for the 8-bit ADD_CARD ALU. Accepts multi-byte commands over a valid/ready port.

---
 rtl/alu_card_pkg.sv | 21 ++
 rtl/alu_seq_wait_ctr.sv | 31 +++
 rtl/alu_card_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_card_pkg.sv
// Shared constants and types for the ADD_CARD sequencer.
// Opcodes 4/5 are the only ones that chain the card's stored carry across bytes.
package alu_card_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADDC = 3'd4;
    localparam logic [2:0] OP_SUBC = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_t;

    function automatic logic is_carry_op(input logic [2:0] op);
        return (op == OP_ADDC) || (op == OP_SUBC);
    endfunction

endpackage

// File: rtl/alu_seq_wait_ctr.sv
// Loadable down-counter that times the ALU latency for one issued byte.
// o_done marks the final WAIT cycle, i.e. the edge on which the card's result is valid.
module alu_seq_wait_ctr #(
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    localparam int CW = $clog2(ALU_LAT) + 1;

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(ALU_LAT);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/alu_card_sequencer.sv
// Master-side driver for the 8-bit ADD_CARD ALU: slices wide operands into bytes (LSB
// first), issues one card op per byte, and returns the assembled result over valid/ready.
module alu_card_sequencer
    import alu_card_pkg::*;
#(
    parameter int BYTES   = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [8*BYTES-1:0]   cmd_a,
    input  logic [8*BYTES-1:0]   cmd_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*BYTES-1:0]   rsp_res,
    output logic                 rsp_sign,
    output logic                 rsp_zero,
    output logic [ALU_W-1:0]     alu_a,
    output logic [ALU_W-1:0]     alu_b,
    output logic [2:0]           alu_op,
    output logic                 alu_csel,
    output logic                 alu_cclear,
    input  logic [ALU_W-1:0]     alu_res,
    input  logic                 alu_sign,
    input  logic                 alu_zero
);

    localparam int DW = ALU_W * BYTES;
    localparam int IW = $clog2(BYTES) + 1;

    if (BYTES < 1 || ALU_LAT < 1) begin : g_param_check
        $error("alu_card_sequencer: BYTES and ALU_LAT must both be >= 1");
    end

    seq_state_t    r_state;
    logic [2:0]    r_op;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [IW-1:0] r_idx;
    logic          r_zero_acc;
    logic          w_ctr_done;

    alu_seq_wait_ctr #(
        .ALU_LAT (ALU_LAT)
    ) u_wait_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == ISSUE),
        .i_dec  (r_state == WAIT),
        .o_done (w_ctr_done)
    );

    // Operands are kept pre-shifted so the next byte to issue is always r_a/r_b[7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_zero_acc <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_res    <= '0;
            rsp_sign   <= 1'b0;
            rsp_zero   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_csel   <= 1'b0;
            alu_cclear <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_a        <= cmd_a >> ALU_W;
                        r_b        <= cmd_b >> ALU_W;
                        r_idx      <= '0;
                        r_zero_acc <= 1'b1;
                        cmd_ready  <= 1'b0;
                        alu_a      <= cmd_a[ALU_W-1:0];
                        alu_b      <= cmd_b[ALU_W-1:0];
                        alu_op     <= cmd_op;
                        alu_csel   <= 1'b0;
                        alu_cclear <= is_carry_op(cmd_op);
                        r_state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_state <= WAIT;
                end

                WAIT: begin
                    if (w_ctr_done) begin
                        // Results shift in from the top; after BYTES steps byte 0 sits at the LSB.
                        rsp_res    <= (rsp_res >> ALU_W) | (DW'(alu_res) << (DW - ALU_W));
                        rsp_sign   <= alu_sign;
                        r_zero_acc <= r_zero_acc & alu_zero;
                        if (r_idx == IW'(BYTES - 1)) begin
                            rsp_zero  <= r_zero_acc & alu_zero;
                            rsp_valid <= 1'b1;
                            r_state   <= RESP;
                        end else begin
                            r_idx      <= r_idx + IW'(1);
                            r_a        <= r_a >> ALU_W;
                            r_b        <= r_b >> ALU_W;
                            alu_a      <= r_a[ALU_W-1:0];
                            alu_b      <= r_b[ALU_W-1:0];
                            alu_csel   <= is_carry_op(r_op);
                            alu_cclear <= 1'b0;
                            r_state    <= ISSUE;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        cmd_ready  <= 1'b1;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        alu_op     <= '0;
                        alu_csel   <= 1'b0;
                        alu_cclear <= 1'b0;
                        r_state    <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
